// File: rtl/board_pkg.sv
// board_pkg: board-level IMC endpoint constants, QP context type and TX FSM state encoding
package board_pkg;
  typedef struct packed {
    logic [31:0] ip;
    logic [47:0] mac;
    logic [23:0] dst_qpn;
  } qp_ctx_t;
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} tx_state_t;
  localparam logic [31:0] IMC_0_ETH0_IP        = 32'hC0A8_0A02;
  localparam logic [47:0] IMC_0_ETH0_MAC       = 48'h0200_000A_0002;
  localparam logic [23:0] IMC_0_HOST_QPN       = 24'h000011;
  localparam logic [23:0] IMC_0_FPGA_START_PSN = 24'h000100;
  localparam logic [31:0] IMC_1_ETH0_IP        = 32'hC0A8_0A03;
  localparam logic [47:0] IMC_1_ETH0_MAC       = 48'h0200_000A_0003;
  localparam logic [23:0] IMC_1_HOST_QPN       = 24'h000012;
  localparam logic [23:0] IMC_1_FPGA_START_PSN = 24'h002000;
  localparam logic [31:0] IMC_2_ETH0_IP        = 32'hC0A8_0A04;
  localparam logic [47:0] IMC_2_ETH0_MAC       = 48'h0200_000A_0004;
  localparam logic [23:0] IMC_2_HOST_QPN       = 24'h000013;
  localparam logic [23:0] IMC_2_FPGA_START_PSN = 24'h030000;
  function automatic qp_ctx_t imc_ctx(input int i);
    return i == 0 ? '{IMC_0_ETH0_IP, IMC_0_ETH0_MAC, IMC_0_HOST_QPN} :
           i == 1 ? '{IMC_1_ETH0_IP, IMC_1_ETH0_MAC, IMC_1_HOST_QPN} :
           i == 2 ? '{IMC_2_ETH0_IP, IMC_2_ETH0_MAC, IMC_2_HOST_QPN} : '0;
  endfunction
  function automatic logic [23:0] imc_start_psn(input int i);
    return i == 0 ? IMC_0_FPGA_START_PSN :
           i == 1 ? IMC_1_FPGA_START_PSN :
           i == 2 ? IMC_2_FPGA_START_PSN : '0;
  endfunction
endpackage

// File: rtl/psn_window_chk.sv
// psn_window_chk: modular outstanding-PSN window compare and cumulative-ACK range check for one QP
module psn_window_chk #(
  parameter int PSN_W = 24,
  parameter int WIN   = 64
) (
  input  logic [PSN_W-1:0] next_psn,
  input  logic [PSN_W-1:0] acked_psn,
  input  logic [PSN_W-1:0] ack_psn,
  output logic             full,
  output logic             ack_ok
);
  logic [PSN_W-1:0] outstanding, ack_off;
  assign outstanding = next_psn - acked_psn - 1'b1;
  // an ACK is useful only if it lands in [acked+1, next-1], i.e. its offset is below outstanding
  assign ack_off = ack_psn - acked_psn - 1'b1;
  assign ack_ok = ack_off < outstanding;
  assign full = outstanding >= PSN_W'(WIN);
endmodule

// File: rtl/qp_tx_ctx.sv
// qp_tx_ctx: per-packet TX context lookup (IP/MAC/dest QPn/PSN) with per-QP PSN counters.
// Define QP_TX_ACK_TRACK_EN to add ACK tracking and stall lookups while the PSN window is full.
module qp_tx_ctx
  import board_pkg::*;
#(
  parameter int NUM_QP = 3,
  parameter int PSN_W  = 24,
  parameter int WIN    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_qpn,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_ip,
  output logic [47:0]      rsp_mac,
  output logic [23:0]      rsp_dst_qpn,
  output logic [PSN_W-1:0] rsp_psn,
  output logic             rsp_err,
  input  logic             psn_load,
  input  logic [3:0]       psn_load_qpn,
  input  logic [PSN_W-1:0] psn_load_val,
  input  logic             ack_valid,
  input  logic [3:0]       ack_qpn,
  input  logic [PSN_W-1:0] ack_psn
);
  tx_state_t state, state_nx;
  logic [3:0] qpn_q, idx, ld_idx;
  logic hit, ld_hit, stall, lk_go, inc;
  logic [PSN_W-1:0] next_psn [NUM_QP];
  logic [PSN_W-1:0] cur_psn;
  qp_ctx_t cur_ctx;
  assign idx = qpn_q - 4'd2;
  assign ld_idx = psn_load_qpn - 4'd2;
  assign hit = qpn_q >= 4'd2 && int'(qpn_q) <= NUM_QP + 1;
  assign ld_hit = psn_load_qpn >= 4'd2 && int'(psn_load_qpn) <= NUM_QP + 1;
  assign lk_go = state == LOOKUP && !stall;
  assign inc = state == RESP && rsp_ready && hit;
  assign req_ready = rst_n && state == IDLE;
  assign rsp_valid = state == RESP;
  always_comb begin
    cur_psn = '0;
    cur_ctx = '0;
    for (int i = 0; i < NUM_QP; i++)
      if (hit && idx == 4'(i)) begin
        cur_psn = next_psn[i];
        cur_ctx = imc_ctx(i);
      end
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE && req_valid) state_nx = LOOKUP;
    else if (lk_go) state_nx = RESP;
    else if (state == RESP && rsp_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      qpn_q       <= '0;
      rsp_err     <= 1'b0;
      rsp_ip      <= '0;
      rsp_mac     <= '0;
      rsp_dst_qpn <= '0;
      rsp_psn     <= '0;
    end else begin
      state <= state_nx;
      if (req_valid && req_ready) qpn_q <= req_qpn;
      if (lk_go) begin
        rsp_err     <= !hit;
        rsp_ip      <= cur_ctx.ip;
        rsp_mac     <= cur_ctx.mac;
        rsp_dst_qpn <= cur_ctx.dst_qpn;
        rsp_psn     <= cur_psn;
      end
    end
  // a software load on the same QP overrides the handshake increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NUM_QP; i++) next_psn[i] <= PSN_W'(imc_start_psn(i));
    else
      for (int i = 0; i < NUM_QP; i++)
        if (psn_load && ld_hit && ld_idx == 4'(i)) next_psn[i] <= psn_load_val;
        else if (inc && idx == 4'(i)) next_psn[i] <= next_psn[i] + 1'b1;
`ifdef QP_TX_ACK_TRACK_EN
  logic [3:0] ak_idx;
  logic ak_hit;
  logic [PSN_W-1:0] acked_psn [NUM_QP];
  logic [NUM_QP-1:0] full, ack_ok;
  assign ak_idx = ack_qpn - 4'd2;
  assign ak_hit = ack_qpn >= 4'd2 && int'(ack_qpn) <= NUM_QP + 1;
  for (genvar g = 0; g < NUM_QP; g++) begin : g_chk
    psn_window_chk #(.PSN_W(PSN_W), .WIN(WIN)) u_chk (
      .next_psn (next_psn[g]),
      .acked_psn(acked_psn[g]),
      .ack_psn  (ack_psn),
      .full     (full[g]),
      .ack_ok   (ack_ok[g])
    );
  end
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NUM_QP; i++)
      if (hit && idx == 4'(i)) stall = full[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NUM_QP; i++) acked_psn[i] <= PSN_W'(imc_start_psn(i)) - 1'b1;
    else
      for (int i = 0; i < NUM_QP; i++)
        if (ack_valid && ak_hit && ak_idx == 4'(i) && ack_ok[i]) acked_psn[i] <= ack_psn;
`else
  logic unused_ack;
  assign unused_ack = ^{ack_valid, ack_qpn, ack_psn} ^ 1'(WIN);
  assign stall = 1'b0;
`endif
endmodule

// File: tb/tb_qp_tx_ctx.sv
// tb_qp_tx_ctx: directed vector table plus hand sequences for hold, load priority, reset and window stall
module tb_qp_tx_ctx;
  import board_pkg::*;
`ifdef QP_TX_ACK_TRACK_EN
  localparam int TB_WIN = 4;
`else
  localparam int TB_WIN = 64;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [3:0] req_qpn = '0, psn_load_qpn = '0, ack_qpn = '0;
  logic [31:0] rsp_ip;
  logic [47:0] rsp_mac;
  logic [23:0] rsp_dst_qpn, rsp_psn, psn_load_val = '0, ack_psn = '0;
  logic psn_load = 1'b0, ack_valid = 1'b0;
  int n_vec = 0, n_bad = 0;

  qp_tx_ctx #(.NUM_QP(3), .PSN_W(24), .WIN(TB_WIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_qpn(req_qpn),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ip(rsp_ip), .rsp_mac(rsp_mac), .rsp_dst_qpn(rsp_dst_qpn),
    .rsp_psn(rsp_psn), .rsp_err(rsp_err),
    .psn_load(psn_load), .psn_load_qpn(psn_load_qpn), .psn_load_val(psn_load_val),
    .ack_valid(ack_valid), .ack_qpn(ack_qpn), .ack_psn(ack_psn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic err;
    logic [31:0] ip;
    logic [47:0] mac;
    logic [23:0] dq;
    logic [23:0] psn;
  } rsp_t;

  typedef struct {
    logic [3:0] qpn;
    bit ld;
    logic [23:0] ldv;
    logic err;
    logic [31:0] ip;
    logic [47:0] mac;
    logic [23:0] dq;
    logic [23:0] psn;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_req(input logic [3:0] q, input bit hs, output int lat, output rsp_t r);
    @(negedge clk);
    req_valid = 1'b1;
    req_qpn = q;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = '{rsp_err, rsp_ip, rsp_mac, rsp_dst_qpn, rsp_psn};
    if (hs) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic req_psn(input string nm, input logic [3:0] q, input logic [23:0] exp);
    int lat;
    rsp_t r;
    do_req(q, 1'b1, lat, r);
    chk({nm, "_lat"}, 64'(lat), 64'd2);
    chk({nm, "_psn"}, 64'(r.psn), 64'(exp));
  endtask

  vec_t tv[11];

  initial begin
    int lat, seen;
    rsp_t r;
    tv[0]  = '{4'd2, 0, 24'h0, 1'b0, IMC_0_ETH0_IP, IMC_0_ETH0_MAC, IMC_0_HOST_QPN, 24'h000100};
    tv[1]  = '{4'd2, 0, 24'h0, 1'b0, IMC_0_ETH0_IP, IMC_0_ETH0_MAC, IMC_0_HOST_QPN, 24'h000101};
    tv[2]  = '{4'd7, 0, 24'h0, 1'b1, 32'h0, 48'h0, 24'h0, 24'h0};
    tv[3]  = '{4'd3, 0, 24'h0, 1'b0, IMC_1_ETH0_IP, IMC_1_ETH0_MAC, IMC_1_HOST_QPN, 24'h002000};
    tv[4]  = '{4'd4, 0, 24'h0, 1'b0, IMC_2_ETH0_IP, IMC_2_ETH0_MAC, IMC_2_HOST_QPN, 24'h030000};
    tv[5]  = '{4'd2, 0, 24'h0, 1'b0, IMC_0_ETH0_IP, IMC_0_ETH0_MAC, IMC_0_HOST_QPN, 24'h000102};
    tv[6]  = '{4'd3, 1, 24'hFFFFFE, 1'b0, IMC_1_ETH0_IP, IMC_1_ETH0_MAC, IMC_1_HOST_QPN, 24'hFFFFFE};
    tv[7]  = '{4'd3, 0, 24'h0, 1'b0, IMC_1_ETH0_IP, IMC_1_ETH0_MAC, IMC_1_HOST_QPN, 24'hFFFFFF};
    tv[8]  = '{4'd3, 0, 24'h0, 1'b0, IMC_1_ETH0_IP, IMC_1_ETH0_MAC, IMC_1_HOST_QPN, 24'h000000};
    tv[9]  = '{4'd5, 0, 24'h0, 1'b1, 32'h0, 48'h0, 24'h0, 24'h0};
    tv[10] = '{4'd1, 0, 24'h0, 1'b1, 32'h0, 48'h0, 24'h0, 24'h0};

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_psn", 64'(rsp_psn), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

`ifdef QP_TX_ACK_TRACK_EN
    for (int k = 0; k < 4; k++) req_psn($sformatf("win%0d", k), 4'd4, 24'h030000 + 24'(k));
    @(negedge clk);
    req_valid = 1'b1;
    req_qpn = 4'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    repeat (6) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    chk("win_stall", 64'(seen), 64'd0);
    ack_valid = 1'b1;
    ack_qpn = 4'd4;
    ack_psn = 24'h03000A;
    @(negedge clk);
    ack_valid = 1'b0;
    seen = 0;
    repeat (4) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    chk("win_bad_ack_ignored", 64'(seen), 64'd0);
    ack_valid = 1'b1;
    ack_psn = 24'h030001;
    @(negedge clk);
    ack_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("win_release_valid", 64'(rsp_valid), 64'd1);
    chk("win_release_psn", 64'(rsp_psn), 64'h030004);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
`else
    for (int v = 0; v < 11; v++) begin
      if (tv[v].ld) begin
        @(negedge clk);
        psn_load = 1'b1;
        psn_load_qpn = tv[v].qpn;
        psn_load_val = tv[v].ldv;
        @(negedge clk);
        psn_load = 1'b0;
      end
      do_req(tv[v].qpn, 1'b1, lat, r);
      chk($sformatf("v%0d_lat", v), 64'(lat), 64'd2);
      chk($sformatf("v%0d_err", v), 64'(r.err), 64'(tv[v].err));
      chk($sformatf("v%0d_ip", v), 64'(r.ip), 64'(tv[v].ip));
      chk($sformatf("v%0d_mac", v), 64'(r.mac), 64'(tv[v].mac));
      chk($sformatf("v%0d_dqpn", v), 64'(r.dq), 64'(tv[v].dq));
      chk($sformatf("v%0d_psn", v), 64'(r.psn), 64'(tv[v].psn));
    end

    do_req(4'd3, 1'b0, lat, r);
    chk("ldpri_psn", 64'(r.psn), 64'h000001);
    psn_load = 1'b1;
    psn_load_qpn = 4'd3;
    psn_load_val = 24'h00ABCD;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    psn_load = 1'b0;
    rsp_ready = 1'b0;
    chk("ldpri_done", 64'(rsp_valid), 64'd0);
    req_psn("ldpri_next", 4'd3, 24'h00ABCD);

    do_req(4'd4, 1'b0, lat, r);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold%0d_valid", c), 64'(rsp_valid), 64'd1);
      chk($sformatf("hold%0d_ready", c), 64'(req_ready), 64'd0);
      chk($sformatf("hold%0d_psn", c), 64'(rsp_psn), 64'h030001);
      chk($sformatf("hold%0d_ip", c), 64'(rsp_ip), 64'(IMC_2_ETH0_IP));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_psn("hold_next", 4'd4, 24'h030002);

    do_req(4'd2, 1'b0, lat, r);
    chk("mid_rst_pre_psn", 64'(r.psn), 64'h000103);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_psn", 64'(rsp_psn), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_psn("mid_rst_next", 4'd2, 24'h000100);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
